// File: rtl/dependency_check.sv
// Operand-forwarding select generation from a three-deep destination scoreboard (EX/DM/WB).
// Defining DEPENDENCY_CHECK_LOAD_STALL_EN adds a combinational load-use stall with bubble insertion.
module dependency_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] ins,
  output logic [1:0]  mux_sel_A,
  output logic [1:0]  mux_sel_B,
  output logic        imm_sel,
  output logic [7:0]  imm,
  output logic [4:0]  RW_dm,
  output logic        stall
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 8;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NSLOT = 3;

  localparam logic [SEL_W-1:0] SEL_RF = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EX = 2'b01;
  localparam logic [SEL_W-1:0] SEL_DM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_WB = 2'b11;

  logic             is_imm, no_wr, is_load;
  logic [REG_W-1:0] rw, ra, rb;

  assign is_imm  = ins[23];
  assign no_wr   = ins[22];
  assign is_load = ins[21];
  assign rw      = ins[17:13];
  assign ra      = ins[12:8];
  assign rb      = ins[7:3];

  logic [NSLOT-1:0][REG_W-1:0] slot_rw_q, slot_rw_d;
  logic [NSLOT-1:0]            slot_vld_q, slot_vld_d;
  logic [SEL_W-1:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                        imm_sel_q, imm_sel_d;
  logic [IMM_W-1:0]            imm_q, imm_d;
  logic [REG_W-1:0]            rw_dm_q, rw_dm_d;

  // Youngest valid producer wins; register 0 is never forwarded.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] r,
                                               input logic [NSLOT-1:0][REG_W-1:0] rws,
                                               input logic [NSLOT-1:0] vld);
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (r != '0) begin
      if (vld[0] && (rws[0] == r))      sel = SEL_EX;
      else if (vld[1] && (rws[1] == r)) sel = SEL_DM;
      else if (vld[2] && (rws[2] == r)) sel = SEL_WB;
    end
    return sel;
  endfunction

`ifdef DEPENDENCY_CHECK_LOAD_STALL_EN
  logic ld_q, ld_d;

  // Load in EX feeding a register operand of the decoding instruction.
  always_comb begin
    stall = slot_vld_q[0] & ld_q &
            ((ra == slot_rw_q[0]) | (~is_imm & (rb == slot_rw_q[0])));
  end

  always_comb begin
    ld_d = 1'b0;
    if (!stall) ld_d = is_load & ~no_wr & (rw != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_q <= 1'b0;
    else        ld_q <= ld_d;
  end

  logic unused_ins;
  assign unused_ins = ^ins[20:18];
`else
  assign stall = 1'b0;

  logic unused_ins;
  assign unused_ins = ^{ins[21:18], is_load};
`endif

  // Slots always advance; a stall replaces the new EX entry with a bubble and holds the selects.
  always_comb begin
    slot_rw_d  = slot_rw_q;
    slot_vld_d = slot_vld_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    imm_sel_d  = imm_sel_q;
    imm_d      = imm_q;
    rw_dm_d    = slot_vld_q[0] ? slot_rw_q[0] : '0;

    slot_rw_d[2]  = slot_rw_q[1];
    slot_vld_d[2] = slot_vld_q[1];
    slot_rw_d[1]  = slot_rw_q[0];
    slot_vld_d[1] = slot_vld_q[0];

    if (stall) begin
      slot_vld_d[0] = 1'b0;
    end else begin
      slot_rw_d[0]  = rw;
      slot_vld_d[0] = ~no_wr & (rw != '0);
      sel_a_d       = fwd_sel(ra, slot_rw_q, slot_vld_q);
      sel_b_d       = is_imm ? SEL_RF : fwd_sel(rb, slot_rw_q, slot_vld_q);
      imm_sel_d     = is_imm;
      imm_d         = ins[IMM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_rw_q  <= '0;
      slot_vld_q <= '0;
      sel_a_q    <= SEL_RF;
      sel_b_q    <= SEL_RF;
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
      rw_dm_q    <= '0;
    end else begin
      slot_rw_q  <= slot_rw_d;
      slot_vld_q <= slot_vld_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      imm_sel_q  <= imm_sel_d;
      imm_q      <= imm_d;
      rw_dm_q    <= rw_dm_d;
    end
  end

  assign mux_sel_A = sel_a_q;
  assign mux_sel_B = sel_b_q;
  assign imm_sel   = imm_sel_q;
  assign imm       = imm_q;
  assign RW_dm     = rw_dm_q;

endmodule
